// File: rtl/remote_comm_pkg.sv
// rtl/remote_comm_pkg.sv - shared baud default and state encodings for remote_comm
package remote_comm_pkg;

  localparam int BAUD_DIV_DEFAULT = 2604;
  localparam int FRAME_BITS       = 10;

  typedef enum logic [1:0] {
    IDLE,
    HIGH_BYTE,
    LOW_BYTE
  } seq_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_BUSY
  } tx_state_t;

  typedef enum logic {
    RX_IDLE,
    RX_BUSY
  } rx_state_t;

endpackage

// File: rtl/uart.sv
// rtl/uart.sv - 8N1 byte transmitter and midpoint-sampling receiver
module uart
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       TX,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy
);

  localparam int            CW        = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [3:0]    STOP_IDX  = 4'(FRAME_BITS - 1);

  // ---------------- transmitter ----------------
  tx_state_t     tx_state, tx_state_nxt;
  logic [9:0]    tx_shift;
  logic [CW-1:0] tx_baud;
  logic [3:0]    tx_bit;
  logic          tx_bit_end;
  logic          tx_load;

  assign tx_bit_end = (tx_state == TX_BUSY) && (tx_baud == BIT_LAST);
  assign tx_done    = tx_bit_end && (tx_bit == STOP_IDX);
  // A new frame may be loaded on the last stop-bit cycle so frames abut with no idle gap.
  assign tx_load    = trmt && ((tx_state == TX_IDLE) || tx_done);

  always_comb begin
    tx_state_nxt = tx_state;
    if (tx_load) begin
      tx_state_nxt = TX_BUSY;
    end else if (tx_done) begin
      tx_state_nxt = TX_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_shift <= '1;
      tx_baud  <= '0;
      tx_bit   <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      if (tx_load) begin
        tx_shift <= {1'b1, tx_data, 1'b0};
        tx_baud  <= '0;
        tx_bit   <= '0;
      end else if (tx_done) begin
        tx_shift <= '1;
        tx_baud  <= '0;
        tx_bit   <= '0;
      end else if (tx_bit_end) begin
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx_baud  <= '0;
        tx_bit   <= tx_bit + 4'd1;
      end else if (tx_state == TX_BUSY) begin
        tx_baud <= tx_baud + CW'(1);
      end
    end
  end

  assign TX = tx_shift[0];

  // ---------------- receiver ----------------
  rx_state_t     rx_state, rx_state_nxt;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] rx_baud;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_start;
  logic          rx_sample;

  assign rx_start  = (rx_state == RX_IDLE) && rx_prev && !rx_sync;
  assign rx_sample = (rx_state == RX_BUSY) && (rx_baud == '0);

  always_comb begin
    rx_state_nxt = rx_state;
    if (rx_start) begin
      rx_state_nxt = RX_BUSY;
    end else if (rx_sample && (rx_bit == STOP_IDX)) begin
      rx_state_nxt = RX_IDLE;
    end
  end

  // Sample 0 is the start bit, 1..8 are data, 9 is the (unchecked) stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rdy      <= 1'b0;
    end else begin
      rx_meta  <= RX;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_state_nxt;

      if (rx_start) begin
        rx_baud <= HALF_LAST;
        rx_bit  <= '0;
      end else if (rx_sample) begin
        rx_baud <= BIT_LAST;
        rx_bit  <= rx_bit + 4'd1;
        if ((rx_bit != 4'd0) && (rx_bit != STOP_IDX)) begin
          rx_shift <= {rx_sync, rx_shift[7:1]};
        end
      end else if (rx_state == RX_BUSY) begin
        rx_baud <= rx_baud - CW'(1);
      end

      if (rx_sample && (rx_bit == STOP_IDX)) begin
        rx_data <= rx_shift;
        rdy     <= 1'b1;
      end else if (rx_start || clr_rdy) begin
        rdy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/remote_comm.sv
// rtl/remote_comm.sv - two-byte command sender and response byte receiver over UART
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy
);

  seq_state_t state, state_nxt;
  logic [7:0] cmd_low;
  logic       accept;
  logic       trmt;
  logic [7:0] tx_data;
  logic       tx_done;

  assign accept = (state == IDLE) && send_cmd;

  // The high byte goes straight from cmd so the start bit can begin the cycle after accept.
  always_comb begin
    state_nxt = state;
    trmt      = 1'b0;
    tx_data   = cmd_low;
    case (state)
      IDLE: begin
        if (send_cmd) begin
          trmt      = 1'b1;
          tx_data   = cmd[15:8];
          state_nxt = HIGH_BYTE;
        end
      end
      HIGH_BYTE: begin
        if (tx_done) begin
          trmt      = 1'b1;
          state_nxt = LOW_BYTE;
        end
      end
      LOW_BYTE: begin
        if (tx_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cmd_low  <= '0;
      cmd_sent <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cmd_low  <= cmd[7:0];
        cmd_sent <= 1'b0;
      end else if ((state == LOW_BYTE) && tx_done) begin
        cmd_sent <= 1'b1;
      end
    end
  end

  uart #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart (
    .clk    (clk),
    .rst    (rst),
    .trmt   (trmt),
    .tx_data(tx_data),
    .tx_done(tx_done),
    .TX     (TX),
    .RX     (RX),
    .clr_rdy(accept),
    .rx_data(resp),
    .rdy    (resp_rdy)
  );

endmodule

// File: tb/tb_remote_comm.sv
// tb/tb_remote_comm.sv - self-checking bench for remote_comm
module tb_remote_comm;

  localparam int B = 16;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        send_cmd = 1'b0;
  logic        RX       = 1'b1;
  logic [15:0] cmd      = '0;
  logic        cmd_sent;
  logic        TX;
  logic [7:0]  resp;
  logic        resp_rdy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  remote_comm #(.BAUD_DIV(B)) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd     (cmd),
    .send_cmd(send_cmd),
    .cmd_sent(cmd_sent),
    .TX      (TX),
    .RX      (RX),
    .resp    (resp),
    .resp_rdy(resp_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Decodes TX frames at bit midpoints and pops the expected byte.
  int         mon_cnt   = 0;
  int         mon_idx   = 0;
  bit         mon_busy  = 1'b0;
  logic [7:0] mon_byte  = '0;
  logic       mon_start = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (TX === 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % B == B / 2) begin
        mon_idx = mon_cnt / B;
        if (mon_idx == 0) begin
          mon_start = TX;
        end else if (mon_idx <= 8) begin
          mon_byte = {TX, mon_byte[7:1]};
        end else begin
          chk("tx_frame", {30'h0, mon_start, TX}, 32'h1);
          if (exp_q.size() == 0) chk("tx_queue", exp_q.size(), 1);
          else chk("tx_byte", {24'h0, mon_byte}, {24'h0, exp_q.pop_front()});
          mon_busy = 1'b0;
        end
      end
    end
  end

  logic rdy_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst && resp_rdy === 1'b1 && rdy_prev !== 1'b1) begin
      if (rx_q.size() == 0) chk("rx_queue", rx_q.size(), 1);
      else chk("rx_byte", {24'h0, resp}, {24'h0, rx_q.pop_front()});
    end
    rdy_prev = resp_rdy;
  end

  task automatic send(input logic [15:0] c);
    cmd      = c;
    send_cmd = 1'b1;
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
    cyc(1);
    send_cmd = 1'b0;
    cmd      = ~c;
    chk("start_bit", TX, 0);
    chk("sent_clr", cmd_sent, 0);
    chk("rdy_clr_on_send", resp_rdy, 0);
  endtask

  task automatic wait_sent(input int extra, input int poke_at, input logic [15:0] poke_cmd);
    int   n       = 0;
    int   rise_at = -1;
    int   rises   = 0;
    logic prev    = 1'b0;
    while (n < 20 * B + extra) begin
      if (n + 1 == poke_at) begin
        cmd      = poke_cmd;
        send_cmd = 1'b1;
      end else begin
        send_cmd = 1'b0;
      end
      cyc(1);
      n++;
      if (cmd_sent === 1'b1 && prev !== 1'b1) begin
        rises++;
        if (rise_at < 0) rise_at = n;
      end
      prev = cmd_sent;
    end
    send_cmd = 1'b0;
    chk("sent_latency", rise_at, 20 * B);
    chk("sent_rises", rises, 1);
    chk("sent_level", cmd_sent, 1);
    chk("tx_drained", exp_q.size(), 0);
  endtask

  task automatic rx_byte(input logic [7:0] b, input bit check_clear, input logic [7:0] prev_byte);
    rx_q.push_back(b);
    RX = 1'b0;
    if (check_clear) begin
      cyc(5);
      chk("rdy_clr_on_start", resp_rdy, 0);
      chk("resp_hold", resp, prev_byte);
      cyc(B - 5);
    end else begin
      cyc(B);
    end
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      cyc(B);
    end
    RX = 1'b1;
    cyc(B);
  endtask

  initial begin
    int bad;
    cyc(3);
    chk("rst_tx", TX, 1);
    chk("rst_sent", cmd_sent, 0);
    chk("rst_resp", resp, 0);
    chk("rst_rdy", resp_rdy, 0);
    rst = 1'b0;
    cyc(2);

    rx_byte(8'hA5, 1'b0, 8'h00);
    chk("resp_a5", resp, 8'hA5);
    chk("rdy_a5", resp_rdy, 1);

    rx_byte(8'h3C, 1'b1, 8'hA5);
    chk("resp_3c", resp, 8'h3C);
    chk("rdy_3c", resp_rdy, 1);

    send(16'h2000);
    wait_sent(0, 0, 16'h0000);

    send(16'h43F1);
    wait_sent(2 * B, 0, 16'h0000);

    send(16'h1357);
    wait_sent(2 * B, 5 * B, 16'hFFFF);

    fork
      begin
        send(16'h4BF1);
        wait_sent(0, 0, 16'h0000);
      end
      rx_byte(8'h5A, 1'b0, 8'h00);
    join
    chk("resp_5a", resp, 8'h5A);
    chk("rdy_5a", resp_rdy, 1);

    send(16'h1234);
    cyc(3 * B);
    rst = 1'b1;
    #1;
    chk("rst_mid_tx", TX, 1);
    chk("rst_mid_sent", cmd_sent, 0);
    chk("rst_mid_rdy", resp_rdy, 0);
    chk("rst_mid_resp", resp, 0);
    exp_q.delete();
    cyc(2);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 25 * B; i++) begin
      cyc(1);
      if (TX !== 1'b1 || cmd_sent !== 1'b0) bad++;
    end
    chk("quiet_after_rst", bad, 0);

    send(16'h1E0F);
    wait_sent(0, 0, 16'h0000);
    cyc(B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
